// File: rtl/branch_reservation_station.sv
// In-order reservation station for branch/jump ops: holds dispatched ops in a
// circular buffer, wakes operands from the CDB, and issues only the oldest entry.
module branch_reservation_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         dispatch_valid,
  output logic                         dispatch_ready,
  input  logic [4:0]                   dispatch_op,
  input  logic [4:0]                   dispatch_rd,
  input  logic [31:0]                  dispatch_pc,
  input  logic [31:0]                  dispatch_imm,
  input  logic                         dispatch_src1_rdy,
  input  logic                         dispatch_src2_rdy,
  input  logic [31:0]                  dispatch_src1,
  input  logic [31:0]                  dispatch_src2,
  input  logic [TAG_W-1:0]             dispatch_tag1,
  input  logic [TAG_W-1:0]             dispatch_tag2,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [105:0]                 issue_rs,
  output logic [31:0]                  issue_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               busy_q   [DEPTH];
  logic               busy_d   [DEPTH];
  logic [4:0]         op_q     [DEPTH];
  logic [4:0]         op_d     [DEPTH];
  logic [4:0]         rd_q     [DEPTH];
  logic [4:0]         rd_d     [DEPTH];
  logic [31:0]        pc_q     [DEPTH];
  logic [31:0]        pc_d     [DEPTH];
  logic [31:0]        imm_q    [DEPTH];
  logic [31:0]        imm_d    [DEPTH];
  logic               s1_rdy_q [DEPTH];
  logic               s1_rdy_d [DEPTH];
  logic [TAG_W-1:0]   s1_tag_q [DEPTH];
  logic [TAG_W-1:0]   s1_tag_d [DEPTH];
  logic [31:0]        s1_val_q [DEPTH];
  logic [31:0]        s1_val_d [DEPTH];
  logic               s2_rdy_q [DEPTH];
  logic               s2_rdy_d [DEPTH];
  logic [TAG_W-1:0]   s2_tag_q [DEPTH];
  logic [TAG_W-1:0]   s2_tag_d [DEPTH];
  logic [31:0]        s2_val_q [DEPTH];
  logic [31:0]        s2_val_d [DEPTH];

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               dispatch_fire_s;
  logic               issue_fire_s;
  logic               disp_hit1_s;
  logic               disp_hit2_s;

  // Handshake and head-entry presentation, all from registered state.
  always_comb begin
    dispatch_ready  = (count_q < CNT_W'(DEPTH));
    issue_valid     = busy_q[head_q] && s1_rdy_q[head_q] && s2_rdy_q[head_q];
    issue_rs        = {op_q[head_q], rd_q[head_q], s1_val_q[head_q],
                       s2_val_q[head_q], imm_q[head_q]};
    issue_pc        = pc_q[head_q];
    count           = count_q;
    dispatch_fire_s = dispatch_valid && dispatch_ready;
    issue_fire_s    = issue_valid && issue_ready;
    disp_hit1_s     = cdb_valid && (cdb_tag == dispatch_tag1);
    disp_hit2_s     = cdb_valid && (cdb_tag == dispatch_tag2);
  end

  // Next-state: CDB wakeup, issue retire, dispatch write, then flush override.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      busy_d[i]   = busy_q[i];
      op_d[i]     = op_q[i];
      rd_d[i]     = rd_q[i];
      pc_d[i]     = pc_q[i];
      imm_d[i]    = imm_q[i];
      s1_tag_d[i] = s1_tag_q[i];
      s2_tag_d[i] = s2_tag_q[i];
      if (busy_q[i] && !s1_rdy_q[i] && cdb_valid && (cdb_tag == s1_tag_q[i])) begin
        s1_rdy_d[i] = 1'b1;
        s1_val_d[i] = cdb_data;
      end else begin
        s1_rdy_d[i] = s1_rdy_q[i];
        s1_val_d[i] = s1_val_q[i];
      end
      if (busy_q[i] && !s2_rdy_q[i] && cdb_valid && (cdb_tag == s2_tag_q[i])) begin
        s2_rdy_d[i] = 1'b1;
        s2_val_d[i] = cdb_data;
      end else begin
        s2_rdy_d[i] = s2_rdy_q[i];
        s2_val_d[i] = s2_val_q[i];
      end
    end

    if (issue_fire_s) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end else begin
      head_d         = head_q;
    end

    // A dispatched operand whose producer broadcasts this cycle is captured ready.
    if (dispatch_fire_s) begin
      busy_d[tail_q]   = 1'b1;
      op_d[tail_q]     = dispatch_op;
      rd_d[tail_q]     = dispatch_rd;
      pc_d[tail_q]     = dispatch_pc;
      imm_d[tail_q]    = dispatch_imm;
      s1_tag_d[tail_q] = dispatch_tag1;
      s2_tag_d[tail_q] = dispatch_tag2;
      s1_rdy_d[tail_q] = dispatch_src1_rdy || disp_hit1_s;
      s2_rdy_d[tail_q] = dispatch_src2_rdy || disp_hit2_s;
      s1_val_d[tail_q] = dispatch_src1_rdy ? dispatch_src1 : cdb_data;
      s2_val_d[tail_q] = dispatch_src2_rdy ? dispatch_src2 : cdb_data;
      tail_d           = tail_q + PTR_W'(1);
    end else begin
      tail_d           = tail_q;
    end

    case ({dispatch_fire_s, issue_fire_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_d[i] = 1'b0;
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      count_d = count_d;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= 1'b0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        busy_q[i] <= busy_d[i];
      end
    end
  end

  // Payload and operand state; only meaningful while the entry is busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        s1_rdy_q[i] <= 1'b0;
        s2_rdy_q[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        s1_rdy_q[i] <= s1_rdy_d[i];
        s2_rdy_q[i] <= s2_rdy_d[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      op_q[i]     <= op_d[i];
      rd_q[i]     <= rd_d[i];
      pc_q[i]     <= pc_d[i];
      imm_q[i]    <= imm_d[i];
      s1_tag_q[i] <= s1_tag_d[i];
      s2_tag_q[i] <= s2_tag_d[i];
      s1_val_q[i] <= s1_val_d[i];
      s2_val_q[i] <= s2_val_d[i];
    end
  end

endmodule

// File: tb/tb_branch_reservation_station.sv
// Directed bench for branch_reservation_station: hand-computed expectations
// checked with immediate assertions.
module tb_branch_reservation_station;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         dispatch_valid;
  logic         dispatch_ready;
  logic [4:0]   dispatch_op;
  logic [4:0]   dispatch_rd;
  logic [31:0]  dispatch_pc;
  logic [31:0]  dispatch_imm;
  logic         dispatch_src1_rdy;
  logic         dispatch_src2_rdy;
  logic [31:0]  dispatch_src1;
  logic [31:0]  dispatch_src2;
  logic [4:0]   dispatch_tag1;
  logic [4:0]   dispatch_tag2;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [31:0]  cdb_data;
  logic         issue_valid;
  logic         issue_ready;
  logic [105:0] issue_rs;
  logic [31:0]  issue_pc;
  logic [2:0]   count;

  int n_tests;
  int n_fail;

  branch_reservation_station #(.DEPTH(4), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_op(dispatch_op), .dispatch_rd(dispatch_rd),
    .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
    .dispatch_src1_rdy(dispatch_src1_rdy), .dispatch_src2_rdy(dispatch_src2_rdy),
    .dispatch_src1(dispatch_src1), .dispatch_src2(dispatch_src2),
    .dispatch_tag1(dispatch_tag1), .dispatch_tag2(dispatch_tag2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs(issue_rs), .issue_pc(issue_pc), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [105:0] obs, input logic [105:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] pc,
                          input logic [31:0] imm, input logic r1, input logic [31:0] v1,
                          input logic [4:0] t1, input logic r2, input logic [31:0] v2,
                          input logic [4:0] t2);
    dispatch_valid    = 1'b1;
    dispatch_op       = op;
    dispatch_rd       = rd;
    dispatch_pc       = pc;
    dispatch_imm      = imm;
    dispatch_src1_rdy = r1;
    dispatch_src1     = v1;
    dispatch_tag1     = t1;
    dispatch_src2_rdy = r2;
    dispatch_src2     = v2;
    dispatch_tag2     = t2;
  endtask

  task automatic set_cdb(input logic v, input logic [4:0] t, input logic [31:0] d);
    cdb_valid = v;
    cdb_tag   = t;
    cdb_data  = d;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; flush = 1'b0; issue_ready = 1'b0;
    set_disp(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0);
    dispatch_valid = 1'b0;
    set_cdb(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_issue_valid", 106'(issue_valid), 106'(1'b0));
    check("rst_disp_ready", 106'(dispatch_ready), 106'(1'b1));
    check("rst_count", 106'(count), 106'(3'd0));

    // BEQ with both operands ready
    set_disp(5'b00000, 5'd0, 32'h100, 32'h10, 1'b1, 32'h7, 5'd0, 1'b1, 32'h7, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    check("beq_valid", 106'(issue_valid), 106'(1'b1));
    check("beq_rs", issue_rs, {5'b00000, 5'b00000, 32'h7, 32'h7, 32'h10});
    check("beq_pc", 106'(issue_pc), 106'(32'h100));
    check("beq_count1", 106'(count), 106'(3'd1));
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("beq_count0", 106'(count), 106'(3'd0));
    check("beq_empty", 106'(issue_valid), 106'(1'b0));

    // JALR waiting on tag 3; wrong-tag CDB ignored
    set_disp(5'd2, 5'd1, 32'h200, 32'h4, 1'b0, 32'h0, 5'd3, 1'b1, 32'h0, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    check("jalr_wait", 106'(issue_valid), 106'(1'b0));
    set_cdb(1'b1, 5'd4, 32'h1111);
    tick();
    set_cdb(1'b0, 5'd0, 32'h0);
    check("jalr_tag4", 106'(issue_valid), 106'(1'b0));
    set_cdb(1'b1, 5'd3, 32'h2000);
    tick();
    set_cdb(1'b0, 5'd0, 32'h0);
    check("jalr_woke", 106'(issue_valid), 106'(1'b1));
    check("jalr_rs", issue_rs, {5'd2, 5'd1, 32'h2000, 32'h0, 32'h4});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("jalr_count0", 106'(count), 106'(3'd0));

    // Dispatch and CDB with matching tag in the same cycle
    set_disp(5'd1, 5'd2, 32'h300, 32'h8, 1'b0, 32'h0, 5'd5, 1'b1, 32'h1, 5'd0);
    set_cdb(1'b1, 5'd5, 32'hABCD);
    tick();
    dispatch_valid = 1'b0;
    set_cdb(1'b0, 5'd0, 32'h0);
    check("ovl_valid", 106'(issue_valid), 106'(1'b1));
    check("ovl_rs", issue_rs, {5'd1, 5'd2, 32'hABCD, 32'h1, 32'h8});
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    check("ovl_count0", 106'(count), 106'(3'd0));

    // Fill to DEPTH, reject a fifth op, drain in order; then refill across the wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        set_disp(5'd0, 5'(i), 32'(r * 64 + i * 4), 32'h0, 1'b1, 32'(i), 5'd0, 1'b1, 32'(i), 5'd0);
        tick();
      end
      dispatch_valid = 1'b0;
      check("full_count", 106'(count), 106'(3'd4));
      check("full_ready", 106'(dispatch_ready), 106'(1'b0));
      set_disp(5'd0, 5'd9, 32'h999, 32'h0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 5'd0);
      tick();
      dispatch_valid = 1'b0;
      check("full_drop", 106'(count), 106'(3'd4));
      issue_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        check("order_valid", 106'(issue_valid), 106'(1'b1));
        check("order_pc", 106'(issue_pc), 106'(32'(r * 64 + i * 4)));
        tick();
      end
      issue_ready = 1'b0;
      check("drain_count", 106'(count), 106'(3'd0));
      check("drain_valid", 106'(issue_valid), 106'(1'b0));
    end

    // Unready head blocks a ready younger entry
    issue_ready = 1'b1;
    set_disp(5'd3, 5'd4, 32'h500, 32'h0, 1'b0, 32'h0, 5'd2, 1'b1, 32'h5, 5'd0);
    tick();
    set_disp(5'd4, 5'd5, 32'h504, 32'h0, 1'b1, 32'h6, 5'd0, 1'b1, 32'h6, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    check("block_valid", 106'(issue_valid), 106'(1'b0));
    check("block_count", 106'(count), 106'(3'd2));
    set_cdb(1'b1, 5'd2, 32'h22);
    tick();
    set_cdb(1'b0, 5'd0, 32'h0);
    check("head_valid", 106'(issue_valid), 106'(1'b1));
    check("head_pc", 106'(issue_pc), 106'(32'h500));
    check("head_rs", issue_rs, {5'd3, 5'd4, 32'h22, 32'h5, 32'h0});
    tick();
    check("second_valid", 106'(issue_valid), 106'(1'b1));
    check("second_pc", 106'(issue_pc), 106'(32'h504));
    tick();
    issue_ready = 1'b0;
    check("second_count0", 106'(count), 106'(3'd0));

    // Flush then reset mid-operation, each with a concurrent dispatch
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        set_disp(5'd0, 5'd0, 32'(32'h600 + i * 4), 32'h0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h1, 5'd0);
        tick();
      end
      check("pre_count", 106'(count), 106'(3'd3));
      set_disp(5'd0, 5'd0, 32'h6F0, 32'h0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h1, 5'd0);
      if (k == 0) flush = 1'b1;
      else reset = 1'b1;
      tick();
      flush = 1'b0;
      reset = 1'b0;
      dispatch_valid = 1'b0;
      check("clr_count", 106'(count), 106'(3'd0));
      check("clr_valid", 106'(issue_valid), 106'(1'b0));
      check("clr_ready", 106'(dispatch_ready), 106'(1'b1));
    end

    // Station resumes cleanly after the reset
    set_disp(5'd6, 5'd7, 32'h700, 32'h3, 1'b1, 32'hA, 5'd0, 1'b1, 32'hB, 5'd0);
    tick();
    dispatch_valid = 1'b0;
    check("post_valid", 106'(issue_valid), 106'(1'b1));
    check("post_rs", issue_rs, {5'd6, 5'd7, 32'hA, 32'hB, 32'h3});
    check("post_pc", 106'(issue_pc), 106'(32'h700));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_reservation_station.md
Name: branch_reservation_station

Overview:
- In-order reservation station for branch/jump ops. Sits between dispatch and the branch execute stage.
- Holds dispatched branch ops and snoops the common data bus (CDB) to capture missing operands.
- Presents the oldest op, once both operands are ready, as the 106-bit bundle {op[4:0], rd[4:0], src1[31:0], src2[31:0], imm[31:0]} plus its PC.
- Branches issue strictly in program order.

Parameters:
- DEPTH, 4, number of entries; power of 2, ≥2.
- TAG_W, 5, width of the producer tag carried for unready operands.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all entries (mispredict recovery)
- dispatch_valid  input  1  new op offered
- dispatch_ready  output  1  space available (count < DEPTH)
- dispatch_op  input  5  branch opcode
- dispatch_rd  input  5  destination register
- dispatch_pc  input  32  op PC
- dispatch_imm  input  32  immediate
- dispatch_src1_rdy / dispatch_src2_rdy  input  1 each  operand value already valid
- dispatch_src1 / dispatch_src2  input  32 each  operand value, used when rdy=1
- dispatch_tag1 / dispatch_tag2  input  TAG_W each  producer tag, used when rdy=0
- cdb_valid  input  1  broadcast valid
- cdb_tag  input  TAG_W  broadcast producer tag
- cdb_data  input  32  broadcast value
- issue_valid  output  1  head entry occupied and both operands ready
- issue_ready  input  1  execute stage accepts
- issue_rs  output  106  {op, rd, src1, src2, imm} of head
- issue_pc  output  32  PC of head
- count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries. Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. Each entry holds: busy, op, rd, pc, imm, and per operand {rdy, tag, value}.
- Reset (synchronous): all busy=0; head=tail=0; count=0. Outputs after reset: issue_valid=0, dispatch_ready=1, count=0.
- Flush: same effect as reset, one cycle. Flush has priority over dispatch, issue and CDB in that cycle; a simultaneous dispatch is dropped.
- Dispatch: accepted when dispatch_valid && dispatch_ready. The entry is written at tail, tail+1, and the entry becomes busy next cycle.
- dispatch_ready depends only on count < DEPTH. A full station with a concurrent issue still refuses dispatch; there is no same-cycle slot reuse.
- CDB wakeup, every cycle, for every busy entry and each operand with rdy=0: if cdb_valid && cdb_tag==tag, then value←cdb_data and rdy←1 (registered).
- Dispatch/CDB overlap: if a dispatched operand has rdy=0 and its tag matches the same-cycle CDB broadcast, the entry is written with rdy=1 and value=cdb_data.
- issue_valid = busy[head] && src1.rdy[head] && src2.rdy[head]. It is combinational from the registered entry state; there is no CDB-to-issue bypass.
- Minimum latencies:
  - dispatch with both operands ready into an empty station → issue_valid the next cycle.
  - CDB wakeup of the head's last operand → issue_valid the next cycle.
- issue_rs and issue_pc are driven from head whenever busy[head]. Their values are don't-care when issue_valid=0.
- Issue: on issue_valid && issue_ready, busy[head]←0 and head+1. Only the head may issue; a ready younger entry waits behind an unready head.
- Count: +1 on accepted dispatch, −1 on issue. Simultaneous dispatch and issue leave count unchanged.
- Empty: issue_valid=0 and head==tail. Full: count==DEPTH and dispatch_ready=0.
- Operand values and tags of non-busy entries are don't-care. CDB matches against non-busy entries have no effect.

Test Plan:
- Reset then dispatch BEQ (op=5'b00000, rd=0, pc=0x100, imm=0x10, src1=src2=7, both rdy) → issue_valid=1 next cycle; issue_rs={00000,00000,0x7,0x7,0x10}; issue_pc=0x100; count=1, then 0 after issue_ready.
- Dispatch JALR with src1 rdy=0, tag1=3 → issue_valid stays 0. Drive cdb_valid, tag=3, data=0x2000 → next cycle issue_valid=1 with src1=0x2000. A CDB with tag=4 has no effect.
- Dispatch with tag1=5 in the same cycle as CDB tag=5, data=0xABCD → entry captured ready; issue_valid=1 the next cycle with src1=0xABCD.
- Hold issue_ready=0 and dispatch DEPTH=4 ops with ready operands → count=4, dispatch_ready=0. A 5th dispatch is ignored. Enable issue_ready → ops exit in dispatch order (pc 0x0,0x4,0x8,0xC); pointers wrap correctly on a following refill of 4.
- Head waiting on tag 2, second entry ready → second entry does not issue. CDB tag 2 → head issues, then second entry issues on the following cycle.
- With 3 entries held, assert flush together with dispatch_valid → next cycle count=0, issue_valid=0, dispatch_ready=1. Repeat using reset mid-operation → identical result.
